// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  localparam int unsigned PAT_W_DEF = 5;
  localparam int unsigned LEN_W_DEF = $clog2(PAT_W_DEF + 1);
  localparam logic [PAT_W_DEF-1:0] PAT_DEF_VAL = 5'b10110;

  // Lengths above the pattern register width saturate to the full width.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
    return (len > pat_w) ? pat_w : len;
  endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter, cleared by reset or by a configuration load.
module seq_det_match_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_det_prog.sv
// Mealy serial sequence detector with a runtime-programmable pattern and overlap mode.
// Optional match counter enabled by defining SEQ_MATCH_CNT_EN.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_DEF = PAT_W'(PAT_DEF_VAL),
  parameter int unsigned      LEN_DEF = 5,
  parameter int unsigned      CNT_W   = 16,
  parameter int unsigned      LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             d_i,
  input  logic             valid_i,
  input  logic             cfg_load_i,
  input  logic [PAT_W-1:0] cfg_pat_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             cfg_ovl_i,
  output logic             sd_o
`ifdef SEQ_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_o
`endif
);

  localparam logic [LEN_W-1:0] FillMax = LEN_W'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [PAT_W-2:0] hist_d, hist_q;
  logic [LEN_W-1:0] fill_d, fill_q;

  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len_clamped;
  logic             fill_ok;
  logic             hit;

  assign cand        = {hist_q, d_i};
  assign len_clamped = LEN_W'(clamp_len(32'(cfg_len_i), PAT_W));

  // Only the low len_q bits of the candidate window take part in the compare.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i] = (i < 32'(len_q));
    end
  end

  // fill + 1 >= len_q, evaluated one bit wider so len_q - 1 never underflows.
  assign fill_ok = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q};

  assign hit  = valid_i & (len_q != '0) & fill_ok & (((cand ^ pat_q) & mask) == '0);
  assign sd_o = hit & ~rst_i & ~cfg_load_i;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (cfg_load_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (valid_i) begin
      hist_d = cand[PAT_W-2:0];
      if (sd_o && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q != FillMax) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pat_q  <= PAT_DEF;
      len_q  <= LEN_W'(LEN_DEF);
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      if (cfg_load_i) begin
        pat_q <= cfg_pat_i;
        len_q <= len_clamped;
        ovl_q <= cfg_ovl_i;
      end
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

`ifdef SEQ_MATCH_CNT_EN
  seq_det_match_cnt #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(cfg_load_i),
    .inc_i(sd_o),
    .cnt_o(cnt_o)
  );
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed and random checks of seq_det_prog against a bit-queue reference model.
module tb_seq_det_prog;

  logic       clk = 1'b0;
  logic       rst_i, d_i, valid_i, cfg_load_i, cfg_ovl_i;
  logic [4:0] cfg_pat_i;
  logic [2:0] cfg_len_i;
  logic       sd_o;
`ifdef SEQ_MATCH_CNT_EN
  logic [15:0] cnt_o;
  logic        sd2;
  logic [1:0]  cnt2;
`endif

  always #5 clk = ~clk;

  seq_det_prog u_dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .d_i       (d_i),
    .valid_i   (valid_i),
    .cfg_load_i(cfg_load_i),
    .cfg_pat_i (cfg_pat_i),
    .cfg_len_i (cfg_len_i),
    .cfg_ovl_i (cfg_ovl_i),
    .sd_o      (sd_o)
`ifdef SEQ_MATCH_CNT_EN
    ,
    .cnt_o     (cnt_o)
`endif
  );

`ifdef SEQ_MATCH_CNT_EN
  seq_det_prog #(
    .CNT_W(2)
  ) u_dut2 (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .d_i       (d_i),
    .valid_i   (valid_i),
    .cfg_load_i(cfg_load_i),
    .cfg_pat_i (cfg_pat_i),
    .cfg_len_i (cfg_len_i),
    .cfg_ovl_i (cfg_ovl_i),
    .sd_o      (sd2),
    .cnt_o     (cnt2)
  );
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit exp_q[$];

  // Reference model: accepted bits since the last clear, newest at the back.
  bit       mdl_bits[$];
  bit [4:0] mdl_pat;
  int       mdl_len;
  bit       mdl_ovl;
  int       mdl_cnt;

  function automatic bit mdl_predict(input bit d);
    int n;
    n = mdl_bits.size();
    if (mdl_len == 0) return 1'b0;
    if (n + 1 < mdl_len) return 1'b0;
    if (d != mdl_pat[0]) return 1'b0;
    for (int i = 1; i < mdl_len; i++) begin
      if (mdl_bits[n-i] != mdl_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic mdl_update(input bit d, input bit v, input bit ld, input bit rst);
    bit m;
    if (rst) begin
      mdl_bits.delete();
      mdl_pat = 5'b10110;
      mdl_len = 5;
      mdl_ovl = 1'b1;
      mdl_cnt = 0;
    end else if (ld) begin
      mdl_bits.delete();
      mdl_pat = cfg_pat_i;
      mdl_len = (cfg_len_i > 3'd5) ? 5 : int'(cfg_len_i);
      mdl_ovl = cfg_ovl_i;
      mdl_cnt = 0;
    end else if (v) begin
      m = mdl_predict(d);
      mdl_bits.push_back(d);
      if (mdl_bits.size() > 8) void'(mdl_bits.pop_front());
      if (m) begin
        mdl_cnt++;
        if (!mdl_ovl) mdl_bits.delete();
      end
    end
  endtask

  task automatic step(input bit d, input bit v, input bit ld, input bit rst, input bit exp);
    bit e;
    d_i        = d;
    valid_i    = v;
    cfg_load_i = ld;
    rst_i      = rst;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    assert (sd_o === e)
    else begin
      n_err++;
      $error("FAIL sd_o step %0d: observed %b expected %b", n_cmp, sd_o, e);
    end
`ifdef SEQ_MATCH_CNT_EN
    n_cmp++;
    assert (sd2 === e)
    else begin
      n_err++;
      $error("FAIL sd_o_cnt2 step %0d: observed %b expected %b", n_cmp, sd2, e);
    end
`endif
    mdl_update(d, v, ld, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string ds, input string es);
    for (int i = 0; i < ds.len(); i++) begin
      step(ds[i] == "1", 1'b1, 1'b0, 1'b0, es[i] == "1");
    end
  endtask

  task automatic load(input bit [4:0] p, input bit [2:0] l, input bit o);
    cfg_pat_i = p;
    cfg_len_i = l;
    cfg_ovl_i = o;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

`ifdef SEQ_MATCH_CNT_EN
  task automatic chk_cnt(input int e16, input int e2);
    n_cmp++;
    assert (cnt_o === 16'(e16))
    else begin
      n_err++;
      $error("FAIL cnt16: observed %0d expected %0d", cnt_o, e16);
    end
    n_cmp++;
    assert (cnt2 === 2'(e2))
    else begin
      n_err++;
      $error("FAIL cnt2: observed %0d expected %0d", cnt2, e2);
    end
  endtask
`endif

  initial begin
    bit d, v, e;
    string ts;
    rst_i = 1'b1; d_i = 1'b0; valid_i = 1'b0; cfg_load_i = 1'b0;
    cfg_pat_i = '0; cfg_len_i = '0; cfg_ovl_i = 1'b0;
    #1;
    // Reset cycle with a valid bit present: sd_o must stay low.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef SEQ_MATCH_CNT_EN
    chk_cnt(0, 0);
`endif

    // Defaults, overlapping.
    run("10110110", "00001001");
`ifdef SEQ_MATCH_CNT_EN
    chk_cnt(2, 2);
`endif

    // Non-overlapping with the same stream.
    load(5'b10110, 3'd5, 1'b0);
    run("10110110", "00001000");

    // Valid gaps with d_i toggling between accepted bits.
    load(5'b10110, 3'd5, 1'b1);
    ts = "10110110";
    for (int i = 0; i < 8; i++) begin
      step(ts[i] == "1", 1'b1, 1'b0, 1'b0, (i == 4) || (i == 7));
      step(i[0], 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Pattern 111, overlapping then non-overlapping.
    load(5'b00111, 3'd3, 1'b1);
    run("111111", "001111");
    load(5'b00111, 3'd3, 1'b0);
    run("111111", "001001");

    // Reset mid-sequence discards history and restores the default pattern.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    run("1011", "0000");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run("0", "0");
    run("10110", "00001");

    // Length 0 disables detection.
    load(5'b10110, 3'd0, 1'b1);
    run("1011011011", "0000000000");

    // Length above PAT_W is clamped.
    load(5'b10110, 3'd7, 1'b1);
    run("10110", "00001");

    // Length 1: every matching bit pulses; counter saturation on the narrow instance.
    load(5'b00001, 3'd1, 1'b1);
    run("10100", "10100");
    load(5'b00001, 3'd1, 1'b1);
    run("11111", "11111");
`ifdef SEQ_MATCH_CNT_EN
    chk_cnt(5, 3);
`endif

    // Random streams against the model.
    void'($urandom(254585));
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 65; i++) begin
      d = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      e = v ? mdl_predict(d) : 1'b0;
      step(d, v, 1'b0, 1'b0, e);
    end
`ifdef SEQ_MATCH_CNT_EN
    chk_cnt(mdl_cnt, (mdl_cnt > 3) ? 3 : mdl_cnt);
`endif
    load(5'b00101, 3'd3, 1'b0);
    for (int i = 0; i < 65; i++) begin
      d = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      e = v ? mdl_predict(d) : 1'b0;
      step(d, v, 1'b0, 1'b0, e);
    end
`ifdef SEQ_MATCH_CNT_EN
    chk_cnt(mdl_cnt, (mdl_cnt > 3) ? 3 : mdl_cnt);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
